fetch_queue: RTL and testbench

- Instruction queue between instruction-memory fetch and decode in the pipelined RISC-V core.
- Buffers fetched {instruction, PC} pairs in a small circular FIFO and presents the head entry to decode.
- Exports the head instruction's immediate field (instr[31:7]), which feeds the immediate extender directly.
- Supports decode back-pressure (stall) and a synchronous flush for taken branches and jumps.

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 79 +++++++
 tb/tb_fetch_queue.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue handshake bundle
// fetch side and decode side of the instruction queue
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [24:0]   out_imm_field;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc,
        input  out_imm_field, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc,
        output out_imm_field, count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular {instr, pc} FIFO between fetch and decode
// registered-only outputs, synchronous flush, async active-low reset
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, empty, push, pop;
    logic [31:0]   head_instr;
    logic [31:0]   head_pc;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = q.in_valid & ~full;
    assign pop   = q.out_ready & ~empty;

    // pointer and occupancy update; flush wins over push/pop
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (q.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
            cnt_d    = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // state registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // entry storage; contents need no reset, a flushed write is harmless
    always_ff @(posedge clk) begin
        if (push && !q.flush) begin
            mem_q[wr_ptr_q] <= {q.in_instr, q.in_pc};
        end
    end

    // head presentation: NOP and zero PC when empty
    always_comb begin
        head_instr = NOP_INSTR;
        head_pc    = '0;
        if (!empty) begin
            head_instr = mem_q[rd_ptr_q][63:32];
            head_pc    = mem_q[rd_ptr_q][31:0];
        end
    end

    assign q.in_ready      = ~full;
    assign q.out_valid     = ~empty;
    assign q.out_instr     = head_instr;
    assign q.out_pc        = head_pc;
    assign q.out_imm_field = head_instr[31:7];
    assign q.count         = cnt_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors plus multi-cycle sequences
// for the fetch_queue instruction FIFO
module tb_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    fetch_queue_if #(.DEPTH(4)) bus ();

    fetch_queue #(.DEPTH(4), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        iv;
        logic [31:0] ii;
        logic [31:0] ip;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic        er;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [2:0]  ec;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic ev,
                           input logic er, input logic [31:0] ei,
                           input logic [31:0] ep, input logic [2:0] ec);
        logic [24:0] eimm;
        eimm = ei[31:7];
        chk({nm, ".valid"}, 64'(bus.out_valid), 64'(ev));
        chk({nm, ".ready"}, 64'(bus.in_ready), 64'(er));
        chk({nm, ".instr"}, 64'(bus.out_instr), 64'(ei));
        chk({nm, ".pc"}, 64'(bus.out_pc), 64'(ep));
        chk({nm, ".count"}, 64'(bus.count), 64'(ec));
        chk({nm, ".imm"}, 64'(bus.out_imm_field), 64'(eimm));
    endtask

    task automatic step(input logic iv, input logic [31:0] ii,
                        input logic [31:0] ip, input logic ordy,
                        input logic fl);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_instr  = ii;
        bus.in_pc     = ip;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return {pc[11:0], 20'h00093};
    endfunction

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        vt[0]  = '{"idle",   0, 0, 0, 0, 0, 0, 1, NOP, 0, 0};
        vt[1]  = '{"push0",  1, 32'h00500093, 32'h0, 0, 0,
                   1, 1, 32'h00500093, 32'h0, 1};
        vt[2]  = '{"push1",  1, 32'h00100113, 32'h4, 0, 0,
                   1, 1, 32'h00500093, 32'h0, 2};
        vt[3]  = '{"push2",  1, 32'h00208193, 32'h8, 0, 0,
                   1, 1, 32'h00500093, 32'h0, 3};
        vt[4]  = '{"push3",  1, 32'h40308233, 32'hC, 0, 0,
                   1, 0, 32'h00500093, 32'h0, 4};
        vt[5]  = '{"full",   1, 32'hDEADBEEF, 32'h10, 0, 0,
                   1, 0, 32'h00500093, 32'h0, 4};
        vt[6]  = '{"pop0",   0, 0, 0, 1, 0,
                   1, 1, 32'h00100113, 32'h4, 3};
        vt[7]  = '{"pop1",   0, 0, 0, 1, 0,
                   1, 1, 32'h00208193, 32'h8, 2};
        vt[8]  = '{"pop2",   0, 0, 0, 1, 0,
                   1, 1, 32'h40308233, 32'hC, 1};
        vt[9]  = '{"pop3",   0, 0, 0, 1, 0, 0, 1, NOP, 0, 0};
        vt[10] = '{"popmt",  0, 0, 0, 1, 0, 0, 1, NOP, 0, 0};

        #12;
        chk_all("rst", 0, 1, NOP, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(vt[i].iv, vt[i].ii, vt[i].ip, vt[i].ordy, vt[i].fl);
            chk_all(vt[i].nm, vt[i].ev, vt[i].er, vt[i].ei,
                    vt[i].ep, vt[i].ec);
        end

        step(1, ins(32'h100), 32'h100, 0, 0);
        chk_all("s0", 1, 1, ins(32'h100), 32'h100, 1);
        for (int k = 1; k <= 10; k++) begin
            logic [31:0] pc;
            pc = 32'h100 + 32'(4 * k);
            step(1, ins(pc), pc, 1, 0);
            chk_all("strm", 1, 1, ins(pc), pc, 1);
        end

        step(1, ins(32'h130), 32'h130, 0, 0);
        step(1, ins(32'h134), 32'h134, 0, 0);
        chk_all("pre_fl", 1, 1, ins(32'h128), 32'h128, 3);
        step(1, ins(32'h138), 32'h138, 1, 1);
        chk_all("flush", 0, 1, NOP, 0, 0);
        step(1, ins(32'h200), 32'h200, 0, 0);
        chk_all("post_fl", 1, 1, ins(32'h200), 32'h200, 1);

        step(1, ins(32'h204), 32'h204, 0, 0);
        step(1, ins(32'h208), 32'h208, 0, 0);
        step(1, ins(32'h20C), 32'h20C, 0, 0);
        chk_all("fill", 1, 0, ins(32'h200), 32'h200, 4);

        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async", 0, 1, NOP, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, ins(32'h300), 32'h300, 0, 0);
        chk_all("post_rst", 1, 1, ins(32'h300), 32'h300, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
